mcpu_muldiv: RTL

Multi-cycle integer multiply/divide execution unit for the mcpu core, used for the opcodes the single-cycle ALU does not handle. It accepts one operation through a valid/ready issue handshake, iterates one bit per cycle (shift-add multiply, restoring divide), and holds the result under a valid/ready writeback handshake. It sits beside the ALU in the execute stage. The pipeline stalls issue while `start_ready` is low and can abort an in-flight operation with `kill`.

---
 rtl/mcpu_muldiv.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mcpu_muldiv.sv
// Multi-cycle multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional signed arithmetic is enabled with MCPU_MULDIV_SIGNED_EN (adds the is_signed input).
module mcpu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clkrst_core_clk,
    input  logic             clkrst_core_rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
`ifdef MCPU_MULDIV_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic             kill,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int AW = 2 * WIDTH;
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             dz_pend_q, dz_pend_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             dbz_q, dbz_d;
    logic             valid_q, valid_d;

    // Operand conditioning at accept
    logic             sgn;
    logic             s1, s2;
    logic [WIDTH-1:0] mag1, mag2;
    logic             op2_zero;

`ifdef MCPU_MULDIV_SIGNED_EN
    assign sgn = is_signed;
`else
    assign sgn = 1'b0;
`endif

    assign s1       = sgn & op1[WIDTH-1];
    assign s2       = sgn & op2[WIDTH-1];
    assign mag1     = s1 ? -op1 : op1;
    assign mag2     = s2 ? -op2 : op2;
    assign op2_zero = (op2 == '0);

    // Multiply step: conditional add into the upper half, then shift the 65-bit {carry,acc} right
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_acc;
    assign mul_sum = b_q[0] ? ({1'b0, acc_q[AW-1:WIDTH]} + {1'b0, a_q})
                            : {1'b0, acc_q[AW-1:WIDTH]};
    assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: {rem,quot} shifts left taking the next dividend bit from b_q
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [AW-1:0]    div_acc;
    assign rem_sh  = {acc_q[AW-1:WIDTH], b_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, a_q};
    assign div_acc = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    logic [AW-1:0]    step_acc;
    logic [WIDTH-1:0] step_b;
    assign step_acc = op_q[1] ? div_acc : mul_acc;
    assign step_b   = op_q[1] ? (b_q << 1) : (b_q >> 1);

    // Sign fix-up applied on the DONE-entry edge
    logic [AW-1:0]    prod_s;
    logic [WIDTH-1:0] quot_s, rem_s;
    logic [WIDTH-1:0] final_res;
    assign prod_s = neg_q ? -step_acc : step_acc;
    assign quot_s = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
    assign rem_s  = neg_q ? -step_acc[AW-1:WIDTH] : step_acc[AW-1:WIDTH];

    always_comb begin
        final_res = prod_s[WIDTH-1:0];
        if (dz_pend_q) begin
            final_res = (op_q == OP_REM) ? b_q : '1;
        end else begin
            case (op_q)
                OP_MUL:  final_res = prod_s[WIDTH-1:0];
                OP_MULH: final_res = prod_s[AW-1:WIDTH];
                OP_DIV:  final_res = quot_s;
                OP_REM:  final_res = rem_s;
                default: final_res = prod_s[WIDTH-1:0];
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        neg_d     = neg_q;
        dz_pend_d = dz_pend_q;
        res_d     = res_q;
        dbz_d     = dbz_q;
        valid_d   = valid_q;

        if (kill) begin
            state_d   = S_IDLE;
            valid_d   = 1'b0;
            dz_pend_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        state_d   = S_BUSY;
                        op_d      = opcode;
                        acc_d     = '0;
                        cnt_d     = '0;
                        dbz_d     = 1'b0;
                        dz_pend_d = 1'b0;
                        neg_d     = (opcode == OP_REM) ? s1 : (s1 ^ s2);
                        if (opcode[1]) begin
                            a_d = mag2;
                            b_d = mag1;
                        end else begin
                            a_d = mag1;
                            b_d = mag2;
                        end
                        // Divide-by-zero skips the iterations: one BUSY cycle gives the 1-cycle latency
                        if (opcode[1] && op2_zero) begin
                            dz_pend_d = 1'b1;
                            cnt_d     = 6'(WIDTH - 1);
                            b_d       = op1;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_d = cnt_q + 6'd1;
                    if (!dz_pend_q) begin
                        acc_d = step_acc;
                        b_d   = step_b;
                    end
                    if (cnt_q == 6'(WIDTH - 1)) begin
                        state_d   = S_DONE;
                        valid_d   = 1'b1;
                        res_d     = final_res;
                        dbz_d     = dz_pend_q;
                        dz_pend_d = 1'b0;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            dz_pend_q <= 1'b0;
            res_q     <= '0;
            dbz_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            dz_pend_q <= dz_pend_d;
            res_q     <= res_d;
            dbz_q     <= dbz_d;
            valid_q   <= valid_d;
        end
    end

    assign start_ready  = (state_q == S_IDLE);
    assign result_valid = valid_q;
    assign result       = res_q;
    assign div_by_zero  = dbz_q;

endmodule
